// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : piso_tx
//  Purpose  : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on
//             a valid/ready handshake and shifts it out one bit per enabled
//             clock, qualified by SER_VALID and an end-of-word LAST flag.
//             A new word may be accepted while the final bit is on the line,
//             giving gapless back-to-back frames.
//  Revision : 1.0  initial release
// ============================================================================
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             n_Reset,
    input  logic             EN,
    input  logic             LOAD_VALID,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             LOAD_READY,
    output logic             SER_OUT,
    output logic             SER_VALID,
    output logic             LAST
);

    localparam int c_CW = $clog2(WIDTH);
    // Count value held while the second-to-last bit is on the line; the
    // following shift presents the final bit and raises LAST.
    localparam logic [c_CW-1:0] c_LAST_CNT = c_CW'(WIDTH - 2);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  w_shift_nxt;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic              r_ser_out;
    logic              w_ser_out_nxt;
    logic              r_ser_valid;
    logic              w_ser_valid_nxt;
    logic              r_last;
    logic              w_last_nxt;

    logic              w_ready;
    logic              w_accept;
    logic              w_first_bit;   // bit presented on the accept edge
    logic              w_next_bit;    // bit presented on the next shift
    logic [WIDTH-1:0]  w_shifted;     // shift register after one shift

    // Bit ordering only changes which end of the register feeds the line.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_first_bit = DATA_IN[0];
            assign w_next_bit  = r_shift[1];
            assign w_shifted   = {1'b0, r_shift[WIDTH-1:1]};
            // Bit 0 has already been sent from DATA_IN when the word is loaded.
            logic w_unused_bit;
            assign w_unused_bit = r_shift[0];
        end else begin : g_msb_first
            assign w_first_bit = DATA_IN[WIDTH-1];
            assign w_next_bit  = r_shift[WIDTH-2];
            assign w_shifted   = {r_shift[WIDTH-2:0], 1'b0};
            // The top bit has already been sent from DATA_IN when the word is loaded.
            logic w_unused_bit;
            assign w_unused_bit = r_shift[WIDTH-1];
        end
    endgenerate

    // Ready while idle, or while the final bit is out so the next word can
    // follow without a gap.
    assign w_ready    = (r_state == S_IDLE) || ((r_state == S_SHIFT) && r_last);
    assign w_accept   = LOAD_VALID && w_ready && EN;

    assign LOAD_READY = w_ready;
    assign SER_OUT    = r_ser_out;
    assign SER_VALID  = r_ser_valid;
    assign LAST       = r_last;

    // State and datapath registers; asynchronous reset aborts any frame.
    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_count     <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_count     <= w_count_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_last      <= w_last_nxt;
        end
    end

    // Next-state and output decode; with EN low everything holds.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_count_nxt     = r_count;
        w_ser_out_nxt   = r_ser_out;
        w_ser_valid_nxt = r_ser_valid;
        w_last_nxt      = r_last;

        if (EN) begin
            if (w_accept) begin
                w_state_nxt     = S_SHIFT;
                w_shift_nxt     = DATA_IN;
                w_count_nxt     = '0;
                w_ser_out_nxt   = w_first_bit;
                w_ser_valid_nxt = 1'b1;
                w_last_nxt      = 1'b0;
            end else if (r_state == S_SHIFT) begin
                if (r_last) begin
                    w_state_nxt     = S_IDLE;
                    w_count_nxt     = '0;
                    w_ser_out_nxt   = 1'b0;
                    w_ser_valid_nxt = 1'b0;
                    w_last_nxt      = 1'b0;
                end else begin
                    w_shift_nxt   = w_shifted;
                    w_count_nxt   = r_count + 1'b1;
                    w_ser_out_nxt = w_next_bit;
                    w_last_nxt    = (r_count == c_LAST_CNT);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_tx
//  Purpose  : Self-checking bench for piso_tx. Drives an MSB-first and an
//             LSB-first instance from shared stimulus, compares both against
//             a word/bit-index reference model every cycle, and pins the model
//             with hand-computed bit sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piso_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         lv = 1'b0;
    logic [W-1:0] din = '0;

    logic rdy_m, so_m, sv_m, last_m;
    logic rdy_l, so_l, sv_l, last_l;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .CLK(clk), .n_Reset(rst_n), .EN(en), .LOAD_VALID(lv), .DATA_IN(din),
        .LOAD_READY(rdy_m), .SER_OUT(so_m), .SER_VALID(sv_m), .LAST(last_m)
    );

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .CLK(clk), .n_Reset(rst_n), .EN(en), .LOAD_VALID(lv), .DATA_IN(din),
        .LOAD_READY(rdy_l), .SER_OUT(so_l), .SER_VALID(sv_l), .LAST(last_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the word in flight and the index of the bit currently
    // on the line in send order (-1 when nothing is being sent).
    int           m_idx  = -1;
    logic [W-1:0] m_word = '0;

    function automatic bit m_ready();
        return (m_idx < 0) || (m_idx == W - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx  = -1;
            m_word = '0;
        end else if (en) begin
            if (lv && m_ready()) begin
                m_word = din;
                m_idx  = 0;
            end else if (m_idx == W - 1) begin
                m_idx = -1;
            end else if (m_idx >= 0) begin
                m_idx = m_idx + 1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_v, e_last, e_rdy, e_m, e_l;
            e_v    = (m_idx >= 0);
            e_last = (m_idx == W - 1);
            e_rdy  = m_ready();
            e_m    = e_v ? m_word[W - 1 - m_idx] : 1'b0;
            e_l    = e_v ? m_word[m_idx] : 1'b0;
            chk("msb_ser_out",   32'(so_m),   32'(e_m));
            chk("msb_ser_valid", 32'(sv_m),   32'(e_v));
            chk("msb_last",      32'(last_m), 32'(e_last));
            chk("msb_ready",     32'(rdy_m),  32'(e_rdy));
            chk("lsb_ser_out",   32'(so_l),   32'(e_l));
            chk("lsb_ser_valid", 32'(sv_l),   32'(e_v));
            chk("lsb_last",      32'(last_l), 32'(e_last));
            chk("lsb_ready",     32'(rdy_l),  32'(e_rdy));
        end
    end

    logic [15:0] bits_m;
    logic [7:0]  bits_l;
    int          nlast;
    int          nrdy;

    initial begin
        // 1. Reset held with the clock running.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ser_out",   32'(so_m),  32'd0);
        chk("rst_ser_valid", 32'(sv_m),  32'd0);
        chk("rst_last",      32'(last_m), 32'd0);
        chk("rst_ready",     32'(rdy_m), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // 2. Single word A5, MSB first.
        en = 1'b1; lv = 1'b1; din = 8'hA5;
        bits_m = '0; nlast = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lv = 1'b0;
            bits_m = {bits_m[14:0], so_m};
            if (last_m) begin
                nlast++;
                chk("t2_last_pos", 32'(i), 32'd7);
            end
        end
        chk("t2_bits", 32'(bits_m[7:0]), 32'hA5);
        chk("t2_nlast", 32'(nlast), 32'd1);
        @(negedge clk);
        chk("t2_idle_valid", 32'(sv_m), 32'd0);
        chk("t2_idle_ready", 32'(rdy_m), 32'd1);

        // 3. A5 with a 3-cycle EN stall after the third bit.
        lv = 1'b1; din = 8'hA5; bits_m = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lv = 1'b0;
            bits_m = {bits_m[14:0], so_m};
            if (i == 2) begin
                en = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("t3_stall_hold", 32'({so_m, sv_m}), 32'b11);
                end
                en = 1'b1;
            end
        end
        chk("t3_bits", 32'(bits_m[7:0]), 32'hA5);
        @(negedge clk);

        // 4. Back-to-back A5 then 3C with LOAD_VALID held.
        lv = 1'b1; din = 8'hA5; bits_m = '0; nlast = 0; nrdy = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) din = 8'h3C;
            if (i == 8) lv = 1'b0;
            bits_m = {bits_m[14:0], so_m};
            if (!sv_m) chk("t4_gap", 32'(i), 32'hFFFF);
            if (last_m) begin
                nlast++;
                chk("t4_last_pos", 32'(i % 8), 32'd7);
            end
            if (rdy_m) begin
                nrdy++;
                chk("t4_ready_pos", 32'(i % 8), 32'd7);
            end
        end
        chk("t4_bits", 32'(bits_m), 32'hA53C);
        chk("t4_nlast", 32'(nlast), 32'd2);
        chk("t4_nready", 32'(nrdy), 32'd2);
        @(negedge clk);

        // 5. FF interrupted by asynchronous reset after the fourth bit.
        lv = 1'b1; din = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lv = 1'b0;
        end
        chk("t5_pre_valid", 32'({so_m, sv_m}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", 32'({so_m, sv_m, last_m}), 32'd0);
        chk("t5_rst_ready", 32'(rdy_m), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_leftover", 32'({sv_m, sv_l}), 32'd0);
        end

        // 6. Word 01, LSB-first instance; a mid-word LOAD_VALID pulse is ignored.
        lv = 1'b1; din = 8'h01; bits_m = '0; bits_l = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lv = 1'b0;
            if (i == 3) begin lv = 1'b1; din = 8'hFF; end
            bits_l = {bits_l[6:0], so_l};
            bits_m = {bits_m[14:0], so_m};
        end
        lv = 1'b0;
        chk("t6_lsb_bits", 32'(bits_l), 32'h80);
        chk("t6_msb_bits", 32'(bits_m[7:0]), 32'h01);
        @(negedge clk);
        chk("t6_idle", 32'({sv_l, rdy_l}), 32'b01);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 3) != 0);
            lv  = ($urandom_range(0, 2) != 0);
            din = W'($urandom);
        end
        en = 1'b1; lv = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
